// File: rtl/ir_receiver.sv
// ----------------------------------------------------------------------------
// ir_receiver
// Decodes 12-bit Sony SIRC frames from a demodulated IR receiver pin.
// The pin is low while the 40 kHz carrier is present; a low period is a
// mark. Bits arrive LSB first, 7 command bits followed by 5 address bits.
// Mark and space widths are measured in prescaled ticks. Noise and malformed
// frames are rejected. Each good frame is presented with a 1-cycle valid pulse.
//
// Ports
//   clk      in   1  system clock
//   reset    in   1  asynchronous, active-high reset
//   ir_in_n  in   1  raw receiver pin, low = mark, asynchronous to clk
//   address  out  5  address of the last good frame
//   command  out  7  command of the last good frame
//   valid    out  1  1-cycle pulse, address/command just updated
//   error    out  1  1-cycle pulse, frame aborted after a valid start mark
//   busy     out  1  high while a frame is being received
// ----------------------------------------------------------------------------
module ir_receiver #(
   parameter int COUNT_GOAL = 2024,
   parameter int START_MIN  = 24,
   parameter int START_MAX  = 40,
   parameter int ONE_MIN    = 12,
   parameter int ZERO_MIN   = 4,
   parameter int BIT_MAX    = 20,
   parameter int SPACE_MIN  = 4,
   parameter int SPACE_MAX  = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ir_in_n,
   output logic [4:0] address,
   output logic [6:0] command,
   output logic       valid,
   output logic       error,
   output logic       busy
);

   // state   | meaning
   // --------+-----------------------------------------------------------
   // S_IDLE  | waiting for a mark to begin a frame
   // S_START | inside the start mark, measuring its width
   // S_SPACE | inside an inter-bit space, waiting for the next data mark
   // S_MARK  | inside a data mark, its width decides the bit value

   localparam int PW = (COUNT_GOAL > 0) ? $clog2(COUNT_GOAL + 1) : 1;
   localparam logic [PW-1:0] PRESC_TC = PW'(COUNT_GOAL);

   localparam logic [5:0] W_START_MIN = 6'(START_MIN);
   localparam logic [5:0] W_START_MAX = 6'(START_MAX);
   localparam logic [5:0] W_ONE_MIN   = 6'(ONE_MIN);
   localparam logic [5:0] W_ZERO_MIN  = 6'(ZERO_MIN);
   localparam logic [5:0] W_BIT_MAX   = 6'(BIT_MAX);
   localparam logic [5:0] W_SPACE_MIN = 6'(SPACE_MIN);
   localparam logic [5:0] W_SPACE_MAX = 6'(SPACE_MAX);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_SPACE,
      S_MARK
   } state_t;

   state_t        state_q;
   logic          sync1_q, sync2_q, mark_q;
   logic          mark_now, rise, fall, edge_det;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick;
   logic [5:0]    width_q, width_d;
   logic [11:0]   shreg_q, shreg_d;
   logic [3:0]    bitcnt_q;
   logic [4:0]    address_q;
   logic [6:0]    command_q;
   logic          valid_q, error_q;
   logic          data_bit;

   // Synchronizers reset to the idle (high) pin level so that leaving reset
   // never manufactures an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         mark_q  <= 1'b0;
      end else begin
         sync1_q <= ir_in_n;
         sync2_q <= sync1_q;
         mark_q  <= mark_now;
      end
   end

   assign mark_now = ~sync2_q;
   assign rise     = mark_now & ~mark_q;
   assign fall     = ~mark_now & mark_q;
   assign edge_det = rise | fall;
   assign tick     = (presc_q == PRESC_TC);

   // Both counters restart on every edge so a width is the number of whole
   // ticks elapsed since the edge that began the current mark or space.
   always_comb begin
      presc_d = presc_q + PW'(1);
      if (edge_det || tick) presc_d = '0;
   end

   always_comb begin
      width_d = width_q;
      if (edge_det)                   width_d = '0;
      else if (tick && width_q != '1) width_d = width_q + 6'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         width_q <= '0;
      end else begin
         presc_q <= presc_d;
         width_q <= width_d;
      end
   end

   assign data_bit = (width_q >= W_ONE_MIN);
   assign shreg_d  = {data_bit, shreg_q[11:1]};

   // Edges take priority over a coincident tick, so a width of exactly the
   // maximum is still accepted. A timeout fires on the tick that would carry
   // the width past its maximum.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         shreg_q   <= '0;
         bitcnt_q  <= '0;
         address_q <= '0;
         command_q <= '0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (rise) begin
                  state_q <= S_START;
                  shreg_q <= '0;
               end
            end
            S_START: begin
               if (fall) begin
                  if (width_q < W_START_MIN) begin
                     state_q <= S_IDLE;
                  end else if (width_q <= W_START_MAX) begin
                     state_q  <= S_SPACE;
                     bitcnt_q <= '0;
                  end else begin
                     state_q <= S_IDLE;
                     error_q <= 1'b1;
                  end
               end else if (tick && width_q >= W_START_MAX) begin
                  state_q <= S_IDLE;
                  error_q <= 1'b1;
               end
            end
            S_SPACE: begin
               if (rise) begin
                  if (width_q >= W_SPACE_MIN && width_q <= W_SPACE_MAX) begin
                     state_q <= S_MARK;
                  end else begin
                     state_q <= S_IDLE;
                     error_q <= 1'b1;
                  end
               end else if (tick && width_q >= W_SPACE_MAX) begin
                  state_q <= S_IDLE;
                  error_q <= 1'b1;
               end
            end
            S_MARK: begin
               if (fall) begin
                  if (width_q < W_ZERO_MIN || width_q > W_BIT_MAX) begin
                     state_q <= S_IDLE;
                     error_q <= 1'b1;
                  end else begin
                     shreg_q  <= shreg_d;
                     bitcnt_q <= bitcnt_q + 4'd1;
                     if (bitcnt_q == 4'd11) begin
                        state_q   <= S_IDLE;
                        address_q <= shreg_d[11:7];
                        command_q <= shreg_d[6:0];
                        valid_q   <= 1'b1;
                     end else begin
                        state_q <= S_SPACE;
                     end
                  end
               end else if (tick && width_q >= W_BIT_MAX) begin
                  state_q <= S_IDLE;
                  error_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign address = address_q;
   assign command = command_q;
   assign valid   = valid_q;
   assign error   = error_q;
   assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ir_receiver.sv
// ----------------------------------------------------------------------------
// tb_ir_receiver
// Self-checking bench for ir_receiver with a 10-clock tick. Frames are
// described as tick widths (start mark, then space/mark pairs) and driven
// with a few clocks of random jitter inside each tick. A reference model
// applies the SIRC width rules to the same description to predict the
// outcome of every frame.
// ----------------------------------------------------------------------------
module tb_ir_receiver;

   localparam int TICK      = 10;
   localparam int START_MIN = 24;
   localparam int START_MAX = 40;
   localparam int ONE_MIN   = 12;
   localparam int ZERO_MIN  = 4;
   localparam int BIT_MAX   = 20;
   localparam int SPACE_MIN = 4;
   localparam int SPACE_MAX = 12;

   logic       clk = 1'b0;
   logic       reset;
   logic       ir_in_n;
   logic [4:0] address;
   logic [6:0] command;
   logic       valid;
   logic       error;
   logic       busy;

   int          vectors     = 0;
   int          miscompares = 0;
   int          valid_cnt   = 0;
   int          err_cnt     = 0;
   int          both_cnt    = 0;
   logic [11:0] last_code   = '0;
   logic [11:0] exp_code    = '0;

   // Current frame description, in ticks.
   int st_t;
   int nb;
   int mk[12];
   int sp[12];

   ir_receiver #(.COUNT_GOAL(9)) dut (
      .clk     (clk),
      .reset   (reset),
      .ir_in_n (ir_in_n),
      .address (address),
      .command (command),
      .valid   (valid),
      .error   (error),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         if (valid) begin
            valid_cnt = valid_cnt + 1;
            last_code = {address, command};
         end
         if (error) err_cnt = err_cnt + 1;
         if (valid && error) both_cnt = both_cnt + 1;
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: time limit reached before the test sequence completed");
      $fatal(1, "watchdog expired");
   end

   function automatic int jit();
      return int'($urandom_range(8, 2));
   endfunction

   function automatic int urange(input int lo, input int hi);
      return int'($urandom_range(hi, lo));
   endfunction

   task automatic seg(input logic lvl, input int n);
      ir_in_n = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input int n);
      ir_in_n = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic set_nominal(input logic [11:0] code);
      st_t = 32;
      nb   = 12;
      for (int i = 0; i < 12; i++) begin
         sp[i] = 8;
         mk[i] = code[i] ? 16 : 8;
      end
   endtask

   task automatic set_random(input logic [11:0] code);
      st_t = urange(START_MIN, START_MAX);
      nb   = 12;
      for (int i = 0; i < 12; i++) begin
         sp[i] = urange(SPACE_MIN, SPACE_MAX);
         mk[i] = code[i] ? urange(ONE_MIN, BIT_MAX) : urange(ZERO_MIN, ONE_MIN - 1);
      end
   endtask

   // Leaves the pin high at the negedge on which the last mark ends.
   task automatic run_frame();
      seg(1'b0, st_t * TICK + jit());
      for (int i = 0; i < nb; i++) begin
         seg(1'b1, sp[i] * TICK + jit());
         seg(1'b0, mk[i] * TICK + jit());
      end
      ir_in_n = 1'b1;
   endtask

   // kind: 0 = ignored as noise, 1 = good frame, 2 = error.
   // Once a frame is abandoned the remaining marks are all shorter than a
   // start mark, so they are ignored as noise and the first verdict stands.
   task automatic model(output int kind, output logic [11:0] code);
      kind = 0;
      code = '0;
      if (st_t < START_MIN) return;
      if (st_t > START_MAX) begin
         kind = 2;
         return;
      end
      for (int i = 0; i < nb; i++) begin
         if (sp[i] < SPACE_MIN || sp[i] > SPACE_MAX) begin
            kind = 2;
            return;
         end
         if (mk[i] < ZERO_MIN || mk[i] > BIT_MAX) begin
            kind = 2;
            return;
         end
         code[i] = (mk[i] >= ONE_MIN);
      end
      kind = (nb == 12) ? 1 : 2;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if ({address, command} !== 12'h000) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h required 000", {address, command});
      end
      vectors++;
      if ({valid, error, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_flags: got valid/error/busy=%b required 000", {valid, error, busy});
      end
      reset = 1'b0;
      repeat (20) @(negedge clk);
      vectors++;
      if ({busy, valid_cnt[0], err_cnt[0]} !== 3'b000) begin
         miscompares++;
         $display("FAIL after_release: busy=%b valids=%0d errors=%0d required all 0", busy, valid_cnt, err_cnt);
      end
   endtask

   task automatic test_nominal();
      int v0, e0, lat;
      set_nominal({5'h01, 7'h15});
      v0 = valid_cnt;
      e0 = err_cnt;
      run_frame();
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (valid === 1'b1) begin
            lat = k;
            break;
         end
      end
      vectors++;
      if (lat !== 3) begin
         miscompares++;
         $display("FAIL nominal_latency: valid after %0d clk required 3", lat);
      end
      drain(400);
      vectors++;
      if ((valid_cnt - v0) !== 1 || (err_cnt - e0) !== 0) begin
         miscompares++;
         $display("FAIL nominal_pulses: valids=%0d errors=%0d required 1 and 0", valid_cnt - v0, err_cnt - e0);
      end
      exp_code = {5'h01, 7'h15};
      vectors++;
      if ({address, command} !== exp_code) begin
         miscompares++;
         $display("FAIL nominal_data: got addr=%h cmd=%h required addr=01 cmd=15", address, command);
      end
   endtask

   task automatic test_back_to_back();
      int v0, busy_hits;
      v0 = valid_cnt;
      set_nominal({5'h1F, 7'h7F});
      run_frame();
      drain(400);
      exp_code = {5'h1F, 7'h7F};
      vectors++;
      if ({address, command} !== exp_code || last_code !== exp_code) begin
         miscompares++;
         $display("FAIL b2b_first: got addr=%h cmd=%h required addr=1f cmd=7f", address, command);
      end
      busy_hits = 0;
      for (int k = 0; k < 26; k++) begin
         repeat (100) @(negedge clk);
         if (busy !== 1'b0) busy_hits++;
      end
      vectors++;
      if (busy_hits !== 0) begin
         miscompares++;
         $display("FAIL b2b_gap_busy: busy high in %0d samples required 0", busy_hits);
      end
      set_nominal({5'h00, 7'h00});
      run_frame();
      drain(400);
      exp_code = 12'h000;
      vectors++;
      if ({address, command} !== exp_code || (valid_cnt - v0) !== 2) begin
         miscompares++;
         $display("FAIL b2b_second: got addr=%h cmd=%h valids=%0d required 00 00 and 2", address, command, valid_cnt - v0);
      end
   endtask

   task automatic test_noise_long_start();
      int v0, e0, kind;
      logic [11:0] code;
      for (int pass = 0; pass < 2; pass++) begin
         st_t = (pass == 0) ? 10 : 45;
         nb   = 0;
         model(kind, code);
         v0 = valid_cnt;
         e0 = err_cnt;
         run_frame();
         drain(400);
         vectors++;
         if ((valid_cnt - v0) !== 0 || (err_cnt - e0) !== ((kind == 2) ? 1 : 0)) begin
            miscompares++;
            $display("FAIL start_width_%0d: valids=%0d errors=%0d required 0 and %0d", st_t, valid_cnt - v0, err_cnt - e0, (kind == 2) ? 1 : 0);
         end
         vectors++;
         if ({address, command} !== exp_code) begin
            miscompares++;
            $display("FAIL start_width_%0d_hold: got %h required %h", st_t, {address, command}, exp_code);
         end
      end
   endtask

   task automatic test_space_timeout();
      int v0, lat;
      set_random(12'($urandom));
      nb = 5;
      v0 = valid_cnt;
      run_frame();
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_busy_during: got %b required 1", busy);
      end
      lat = -1;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (error === 1'b1) begin
            lat = k;
            break;
         end
      end
      // Space passes 12 ticks on the 13th tick after the mark end, plus
      // 3 clk of pin-to-edge latency; allow a tick of slack either side.
      vectors++;
      if (lat < 123 || lat > 143) begin
         miscompares++;
         $display("FAIL timeout_error_time: error after %0d clk required 123..143", lat);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || (valid_cnt - v0) !== 0 || {address, command} !== exp_code) begin
         miscompares++;
         $display("FAIL timeout_after: busy=%b valids=%0d data=%h required 0 0 %h", busy, valid_cnt - v0, {address, command}, exp_code);
      end
      drain(100);
   endtask

   task automatic test_boundaries();
      int v0, e0, kind;
      logic [11:0] code;
      for (int f = 0; f < 4; f++) begin
         set_random(12'($urandom));
         case (f)
            0: begin
               st_t  = START_MIN;
               mk[0] = 4;
               mk[1] = 11;
               mk[2] = 12;
               mk[3] = 20;
               sp[0] = SPACE_MIN;
               sp[1] = SPACE_MAX;
            end
            1: st_t = START_MAX;
            2: mk[urange(0, 11)] = 3;
            default: mk[urange(0, 11)] = 21;
         endcase
         model(kind, code);
         v0 = valid_cnt;
         e0 = err_cnt;
         run_frame();
         drain(400);
         if (kind == 1) exp_code = code;
         vectors++;
         if ((valid_cnt - v0) !== ((kind == 1) ? 1 : 0) || (err_cnt - e0) !== ((kind == 2) ? 1 : 0)) begin
            miscompares++;
            $display("FAIL boundary_%0d_pulses: valids=%0d errors=%0d required %0d and %0d", f, valid_cnt - v0, err_cnt - e0, (kind == 1) ? 1 : 0, (kind == 2) ? 1 : 0);
         end
         vectors++;
         if ({address, command} !== exp_code) begin
            miscompares++;
            $display("FAIL boundary_%0d_data: got %h required %h", f, {address, command}, exp_code);
         end
         if (f == 0) begin
            vectors++;
            if (command[3:0] !== 4'b1100) begin
               miscompares++;
               $display("FAIL boundary_bits_4_11_12_20: got %b required 1100", command[3:0]);
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      int v0, e0, kind;
      logic [11:0] code;
      set_nominal({5'h1F, 7'h55});
      run_frame();
      drain(400);
      exp_code = {5'h1F, 7'h55};
      vectors++;
      if ({address, command} !== exp_code) begin
         miscompares++;
         $display("FAIL prereset_data: got %h required %h", {address, command}, exp_code);
      end
      set_random(12'($urandom));
      v0 = valid_cnt;
      e0 = err_cnt;
      seg(1'b0, st_t * TICK + jit());
      for (int i = 0; i < 6; i++) begin
         seg(1'b1, sp[i] * TICK + jit());
         seg(1'b0, mk[i] * TICK + jit());
      end
      seg(1'b1, sp[6] * TICK + jit());
      seg(1'b0, 2 * TICK);
      reset = 1'b1;
      #1;
      exp_code = 12'h000;
      vectors++;
      if ({address, command} !== exp_code || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_midframe_immediate: data=%h busy=%b required 000 0", {address, command}, busy);
      end
      repeat (4) @(negedge clk);
      ir_in_n = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      drain(400);
      vectors++;
      if ((valid_cnt - v0) !== 0 || (err_cnt - e0) !== 0 || {address, command} !== exp_code) begin
         miscompares++;
         $display("FAIL reset_midframe_quiet: valids=%0d errors=%0d data=%h required 0 0 000", valid_cnt - v0, err_cnt - e0, {address, command});
      end
      set_random(12'($urandom));
      model(kind, code);
      v0 = valid_cnt;
      run_frame();
      drain(400);
      if (kind == 1) exp_code = code;
      vectors++;
      if ((valid_cnt - v0) !== 1 || {address, command} !== exp_code) begin
         miscompares++;
         $display("FAIL reset_midframe_next: valids=%0d data=%h required 1 %h", valid_cnt - v0, {address, command}, exp_code);
      end
   endtask

   task automatic test_random();
      int v0, e0, kind, r;
      logic [11:0] code;
      for (int n = 0; n < 6; n++) begin
         set_random(12'($urandom));
         r = urange(0, 7);
         case (r)
            0: st_t = urange(5, START_MIN - 1);
            1: st_t = urange(START_MAX + 1, 48);
            2: mk[urange(0, 11)] = urange(1, ZERO_MIN - 1);
            3: mk[urange(0, 11)] = urange(BIT_MAX + 1, 26);
            4: sp[urange(0, 11)] = urange(1, SPACE_MIN - 1);
            default: ;
         endcase
         model(kind, code);
         v0 = valid_cnt;
         e0 = err_cnt;
         run_frame();
         drain(400);
         if (kind == 1) exp_code = code;
         vectors++;
         if ((valid_cnt - v0) !== ((kind == 1) ? 1 : 0) || (err_cnt - e0) !== ((kind == 2) ? 1 : 0)) begin
            miscompares++;
            $display("FAIL random_%0d_pulses: valids=%0d errors=%0d required %0d and %0d", n, valid_cnt - v0, err_cnt - e0, (kind == 1) ? 1 : 0, (kind == 2) ? 1 : 0);
         end
         vectors++;
         if ({address, command} !== exp_code) begin
            miscompares++;
            $display("FAIL random_%0d_data: got %h required %h", n, {address, command}, exp_code);
         end
      end
   endtask

   task automatic test_final();
      vectors++;
      if (both_cnt !== 0) begin
         miscompares++;
         $display("FAIL valid_and_error_together: %0d cycles required 0", both_cnt);
      end
   endtask

   initial begin
      reset   = 1'b1;
      ir_in_n = 1'b1;
      test_reset();
      test_nominal();
      test_back_to_back();
      test_noise_long_start();
      test_space_timeout();
      test_boundaries();
      test_reset_midframe();
      test_random();
      test_final();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
